// File: rtl/os_cmd_issuer_pkg.sv
// rtl/os_cmd_issuer_pkg.sv - shared usertypes plus issuer state, strobe select and command types
package os_cmd_issuer_pkg;

  typedef enum logic [3:0] {
    No_action = 4'd0,
    Buy       = 4'd1,
    Check     = 4'd2,
    Deposit   = 4'd4,
    Return    = 4'd8
  } Action;

  typedef enum logic [3:0] {
    No_Err    = 4'b0000,
    Wrong_act = 4'b1111
  } Error_Msg;

  typedef enum logic [1:0] {
    No_item = 2'd0,
    Large   = 2'd1,
    Medium  = 2'd2,
    Small   = 2'd3
  } Item_id;

  typedef logic [7:0]  User_id;
  typedef logic [5:0]  Item_num;
  typedef logic [15:0] Money;
  typedef logic [15:0] DATA;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_WAIT, S_RESP} Issuer_State;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_USER, SEL_SELLER, SEL_ACT, SEL_ITEM, SEL_NUM, SEL_AMNT
  } Strobe_Sel;

  typedef struct packed {
    logic [3:0] act;
    logic       new_user;
    User_id     user;
    Item_id     item;
    Item_num    num;
    User_id     seller;
    logic       has_seller;
    Money       amnt;
  } Os_Cmd;

  function automatic logic act_is_valid(input logic [3:0] a);
    return (a == Buy) || (a == Check) || (a == Deposit) || (a == Return);
  endfunction

endpackage

// File: rtl/os_step_rom.sv
// rtl/os_step_rom.sv - maps (act, new_user, has_seller, step) to the strobe to drive and last-step flag
module os_step_rom
  import os_cmd_issuer_pkg::*;
(
  input  logic [3:0] act,
  input  logic       new_user,
  input  logic       has_seller,
  input  logic [2:0] step,
  output Strobe_Sel  sel,
  output logic       last
);

  logic [2:0] k;

  always_comb begin
    sel  = SEL_NONE;
    last = 1'b0;
    // Skipping the user id strobe shifts every later step down by one slot
    k    = step + {2'b00, ~new_user};
    case (k)
      3'd0: sel = SEL_USER;
      3'd1: begin
        sel  = SEL_ACT;
        last = (act == Check) && !has_seller;
      end
      3'd2: begin
        case (act)
          Buy, Return: sel = SEL_ITEM;
          Deposit: begin sel = SEL_AMNT;   last = 1'b1; end
          Check:   begin sel = SEL_SELLER; last = 1'b1; end
          default: last = 1'b1;
        endcase
      end
      3'd3: begin
        if (act == Buy || act == Return) sel = SEL_NUM;
        else last = 1'b1;
      end
      3'd4: begin
        if (act == Buy || act == Return) sel = SEL_SELLER;
        last = 1'b1;
      end
      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/os_cmd_issuer.sv
// rtl/os_cmd_issuer.sv - serializes one command onto the OS DATA bus and returns the OS response
module os_cmd_issuer
  import os_cmd_issuer_pkg::*;
#(
  parameter int GAP     = 1,
  parameter int TIMEOUT = 1200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_act,
  input  logic        cmd_new_user,
  input  logic [7:0]  cmd_user,
  input  logic [1:0]  cmd_item,
  input  logic [5:0]  cmd_num,
  input  logic [7:0]  cmd_seller,
  input  logic        cmd_has_seller,
  input  logic [15:0] cmd_amnt,
  output logic        id_valid,
  output logic        act_valid,
  output logic        item_valid,
  output logic        num_valid,
  output logic        amnt_valid,
  output logic [15:0] D,
  input  logic        out_valid,
  input  logic [3:0]  err_msg,
  input  logic        complete,
  input  logic [31:0] out_info,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_err,
  output logic        rsp_complete,
  output logic [31:0] rsp_info,
  output logic        rsp_timeout,
  output logic        proto_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  Issuer_State   state, state_nxt;
  Os_Cmd         cmd;
  logic [2:0]    step, gap_cnt;
  logic [TW-1:0] tmo_cnt;
  Strobe_Sel     rom_sel, sel;
  logic          last, accept, tmo_hit;

  os_step_rom u_rom (
    .act        (cmd.act),
    .new_user   (cmd.new_user),
    .has_seller (cmd.has_seller),
    .step       (step),
    .sel        (rom_sel),
    .last       (last)
  );

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
  assign sel       = (state == S_SEND) ? rom_sel : SEL_NONE;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_valid) state_nxt = act_is_valid(cmd_act) ? S_SEND : S_RESP;
      S_SEND: state_nxt = last ? S_WAIT : S_GAP;
      S_GAP:  if (gap_cnt == 3'(GAP - 1)) state_nxt = S_SEND;
      S_WAIT: if (out_valid || tmo_hit) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd          <= '0;
      step         <= '0;
      gap_cnt      <= '0;
      tmo_cnt      <= '0;
      rsp_err      <= '0;
      rsp_complete <= 1'b0;
      rsp_info     <= '0;
      rsp_timeout  <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      if (accept) begin
        cmd <= '{act: cmd_act, new_user: cmd_new_user, user: cmd_user,
                 item: Item_id'(cmd_item), num: cmd_num, seller: cmd_seller,
                 has_seller: cmd_has_seller, amnt: cmd_amnt};
        step <= '0;
        if (!act_is_valid(cmd_act)) begin
          rsp_err      <= Wrong_act;
          rsp_complete <= 1'b0;
          rsp_info     <= '0;
          rsp_timeout  <= 1'b0;
        end
      end
      if (state == S_SEND) begin
        gap_cnt <= '0;
        tmo_cnt <= '0;
        if (!last) step <= step + 3'd1;
      end
      if (state == S_GAP) gap_cnt <= gap_cnt + 3'd1;
      // A response arriving on the final counted cycle beats the timeout
      if (state == S_WAIT) begin
        if (out_valid) begin
          rsp_err      <= err_msg;
          rsp_complete <= complete;
          rsp_info     <= out_info;
          rsp_timeout  <= 1'b0;
        end else if (tmo_hit) begin
          rsp_err      <= No_Err;
          rsp_complete <= 1'b0;
          rsp_info     <= '0;
          rsp_timeout  <= 1'b1;
        end else if (tmo_cnt != '1) begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
      if (out_valid && state != S_WAIT) proto_err <= 1'b1;
    end
  end

  always_comb begin
    id_valid   = (sel == SEL_USER) || (sel == SEL_SELLER);
    act_valid  = (sel == SEL_ACT);
    item_valid = (sel == SEL_ITEM);
    num_valid  = (sel == SEL_NUM);
    amnt_valid = (sel == SEL_AMNT);
    D          = '0;
    case (sel)
      SEL_USER:   D = {8'h00, cmd.user};
      SEL_SELLER: D = {8'h00, cmd.seller};
      SEL_ACT:    D = {12'h000, cmd.act};
      SEL_ITEM:   D = {14'h0000, cmd.item};
      SEL_NUM:    D = {10'h000, cmd.num};
      SEL_AMNT:   D = cmd.amnt;
      default:    D = '0;
    endcase
  end

endmodule
